rib_sram_slave: RTL and testbench



---
 rtl/rib_pkg.sv | 31 +++
 rtl/rib_ram_sp.sv | 35 +++
 rtl/rib_sram_slave.sv | 107 ++++++++++
 tb/tb_rib_sram_slave.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rib_pkg.sv
// Shared RIB bus definitions: widths, direction codes, responder state encoding
// and the request payload bundle.
package rib_pkg;

    localparam int unsigned RIB_AW     = 32;
    localparam int unsigned RIB_DW     = 32;
    localparam int unsigned RIB_MW     = 4;
    localparam int unsigned RIBS_CNT_W = 4;

    localparam logic RIB_WR = 1'b1;
    localparam logic RIB_RD = 1'b0;

    typedef enum logic [1:0] {
        RIBS_IDLE = 2'd0,
        RIBS_WAIT = 2'd1,
        RIBS_RESP = 2'd2
    } ribs_state_e;

    typedef struct packed {
        logic [RIB_AW-1:0] addr;
        logic              wrcs;
        logic [RIB_MW-1:0] mask;
        logic [RIB_DW-1:0] wdata;
    } rib_req_t;

    // Wait-counter load value; zero-wait configurations never enter WAIT.
    function automatic logic [RIBS_CNT_W-1:0] ribs_cnt_init(input int unsigned wait_cyc);
        return (wait_cyc == 0) ? '0 : RIBS_CNT_W'(wait_cyc - 1);
    endfunction

endpackage

// File: rtl/rib_ram_sp.sv
// Single-port synchronous word RAM with byte write enables and a registered
// read port that only updates on read accesses. No reset, block-RAM inferable.
module rib_ram_sp
    import rib_pkg::*;
#(
    parameter int unsigned AW = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [RIB_MW-1:0] be,
    input  logic [RIB_DW-1:0] wdata,
    output logic [RIB_DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [RIB_DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int k = 0; k < int'(RIB_MW); k++) begin
                    if (be[k]) begin
                        mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/rib_sram_slave.sv
// RIB responder serving single read/write transactions from an internal
// byte-maskable word RAM, with configurable wait states and held responses.
module rib_sram_slave
    import rib_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned WAIT_CYC   = 0
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [RIB_AW-1:0] i_ribs_addr,
    input  logic              i_ribs_wrcs,
    input  logic [RIB_MW-1:0] i_ribs_mask,
    input  logic [RIB_DW-1:0] i_ribs_wdata,
    output logic [RIB_DW-1:0] o_ribs_rdata,
    input  logic              i_ribs_req,
    output logic              o_ribs_gnt,
    output logic              o_ribs_rsp,
    input  logic              i_ribs_rdy
);

    localparam logic [RIBS_CNT_W-1:0] CNT_INIT = ribs_cnt_init(WAIT_CYC);

    rib_req_t              req;
    ribs_state_e           state;
    ribs_state_e           state_nxt;
    logic [RIBS_CNT_W-1:0] cnt;
    logic [RIBS_CNT_W-1:0] cnt_nxt;
    logic                  gnt_c;
    logic                  accept_c;
    logic                  rd_vld;
    logic [RIB_DW-1:0]     ram_rdata;
    logic                  unused_addr;

    assign req = '{addr: i_ribs_addr, wrcs: i_ribs_wrcs, mask: i_ribs_mask, wdata: i_ribs_wdata};

    // Low word-offset and high alias bits do not take part in addressing.
    assign unused_addr = ^req.addr;

    // Next state, wait counter and the combinational grant.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_c     = 1'b0;
        accept_c  = 1'b0;

        case (state)
            RIBS_IDLE: gnt_c = 1'b1;
            RIBS_RESP: gnt_c = i_ribs_rdy;
            default:   gnt_c = 1'b0;
        endcase

        accept_c = i_ribs_req & gnt_c;

        case (state)
            RIBS_IDLE, RIBS_RESP: begin
                if (accept_c) begin
                    state_nxt = (WAIT_CYC == 0) ? RIBS_RESP : RIBS_WAIT;
                    cnt_nxt   = CNT_INIT;
                end else if ((state == RIBS_RESP) && i_ribs_rdy) begin
                    state_nxt = RIBS_IDLE;
                end
            end
            RIBS_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RIBS_RESP;
                end else begin
                    cnt_nxt = cnt - RIBS_CNT_W'(1);
                end
            end
            default: state_nxt = RIBS_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state  <= RIBS_IDLE;
            cnt    <= '0;
            rd_vld <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept_c) begin
                rd_vld <= (req.wrcs == RIB_RD);
            end
        end
    end

    // RAM output register is the read response register: it only loads on an
    // accepted read, so it holds through wait states and an unready master.
    rib_ram_sp #(
        .AW (DEPTH_LOG2)
    ) u_ram (
        .clk   (i_clk),
        .en    (accept_c),
        .we    (req.wrcs == RIB_WR),
        .addr  (req.addr[DEPTH_LOG2+1:2]),
        .be    (req.mask),
        .wdata (req.wdata),
        .rdata (ram_rdata)
    );

    assign o_ribs_gnt   = gnt_c;
    assign o_ribs_rsp   = (state == RIBS_RESP);
    assign o_ribs_rdata = rd_vld ? ram_rdata : '0;

endmodule

// File: tb/tb_rib_sram_slave.sv
// Scoreboard bench for rib_sram_slave: three configurations driven one at a
// time, checked against an associative-array memory model.
`timescale 1ns/1ps
module tb_rib_sram_slave;
    import rib_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] addr;
    logic        wrcs;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        req_s;
    logic        rdy_man;
    logic        rdy_rnd;
    logic        rdy_rand;
    logic        rdy_s;
    logic [1:0]  sel;

    logic [2:0]  req_v;
    logic [2:0]  rdy_v;
    logic [2:0]  gnt_v;
    logic [2:0]  rsp_v;
    logic [31:0] rdata_v [3];
    logic        gnt_s;
    logic        rsp_s;
    logic [31:0] rdata_s;

    int          total;
    int          bad;
    int          cyc;
    bit          seen;
    exp_t        sbq[$];
    logic [31:0] mem_m [int];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    assign rdy_s   = rdy_rand ? rdy_rnd : rdy_man;
    assign gnt_s   = gnt_v[sel];
    assign rsp_s   = rsp_v[sel];
    assign rdata_s = rdata_v[sel];

    always_comb begin
        req_v      = '0;
        rdy_v      = '0;
        req_v[sel] = req_s;
        rdy_v[sel] = rdy_s;
    end

    rib_sram_slave #(.DEPTH_LOG2(4), .WAIT_CYC(0)) u_dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_ribs_addr(addr), .i_ribs_wrcs(wrcs),
        .i_ribs_mask(mask), .i_ribs_wdata(wdata), .o_ribs_rdata(rdata_v[0]),
        .i_ribs_req(req_v[0]), .o_ribs_gnt(gnt_v[0]), .o_ribs_rsp(rsp_v[0]),
        .i_ribs_rdy(rdy_v[0]));

    rib_sram_slave #(.DEPTH_LOG2(12), .WAIT_CYC(3)) u_dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_ribs_addr(addr), .i_ribs_wrcs(wrcs),
        .i_ribs_mask(mask), .i_ribs_wdata(wdata), .o_ribs_rdata(rdata_v[1]),
        .i_ribs_req(req_v[1]), .o_ribs_gnt(gnt_v[1]), .o_ribs_rsp(rsp_v[1]),
        .i_ribs_rdy(rdy_v[1]));

    rib_sram_slave #(.DEPTH_LOG2(8), .WAIT_CYC(2)) u_dut_c (
        .i_clk(clk), .i_rstn(rstn), .i_ribs_addr(addr), .i_ribs_wrcs(wrcs),
        .i_ribs_mask(mask), .i_ribs_wdata(wdata), .o_ribs_rdata(rdata_v[2]),
        .i_ribs_req(req_v[2]), .o_ribs_gnt(gnt_v[2]), .o_ribs_rsp(rsp_v[2]),
        .i_ribs_rdy(rdy_v[2]));

    function automatic int dut_dl(input int s);
        case (s)
            0:       return 4;
            1:       return 12;
            default: return 8;
        endcase
    endfunction

    function automatic int dut_wc(input int s);
        case (s)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    // Model key: device number plus word index modulo the device depth.
    function automatic int mkey(input logic [31:0] a);
        int idx;
        idx = int'(a >> 2) & ((1 << dut_dl(int'(sel))) - 1);
        return (int'(sel) << 20) | idx;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: dut=%0d got=%08h expected=%08h t=%0t", nm, sel, act, exp, $time);
        end
    endtask

    // Issue one transaction; the expected response is queued at the accept edge.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] d);
        int          n;
        int          key;
        logic [31:0] e;
        logic [31:0] w;
        n     = 0;
        addr  = a;
        wrcs  = wr;
        mask  = m;
        wdata = d;
        req_s = 1'b1;
        @(negedge clk);
        while (!gnt_s) begin
            n++;
            if (n > 200) begin
                chk("gnt_timeout", 32'(gnt_s), 32'd1);
                req_s = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        key = mkey(a);
        if (wr == RIB_WR) begin
            w = mem_m.exists(key) ? mem_m[key] : 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (m[k]) w[8*k +: 8] = d[8*k +: 8];
            end
            mem_m[key] = w;
            e = 32'h0;
        end else begin
            e = mem_m.exists(key) ? mem_m[key] : 32'h0;
        end
        sbq.push_back('{data: e, due: cyc + dut_wc(int'(sel))});
        req_s = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 32'(sbq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Address whose word index (inside the device depth) is idx; other bits random.
    function automatic logic [31:0] rnd_addr(input int idx);
        logic [31:0] im;
        im = 32'(((1 << dut_dl(int'(sel))) - 1) << 2);
        return ($urandom() & ~im) | 32'(idx << 2);
    endfunction

    // Monitor: compares every presented response against the queue head.
    always @(negedge clk) begin
        if (rstn) begin
            if (sbq.size() == 0) begin
                chk("rsp_without_txn", 32'(rsp_s), 32'd0);
            end else if (rsp_s) begin
                if (!seen) begin
                    chk("rsp_latency", 32'(cyc), 32'(sbq[0].due));
                    seen = 1'b1;
                end
                chk("rdata", rdata_s, sbq[0].data);
                chk("gnt_in_resp", 32'(gnt_s), 32'(rdy_s));
                if (rdy_s) begin
                    void'(sbq.pop_front());
                    seen = 1'b0;
                end
            end else begin
                chk("gnt_while_busy", 32'(gnt_s), 32'd0);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rdy_rnd = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int          c0;
        int          n;
        total    = 0;
        bad      = 0;
        seen     = 1'b0;
        sel      = 2'd0;
        req_s    = 1'b0;
        rdy_man  = 1'b1;
        rdy_rnd  = 1'b0;
        rdy_rand = 1'b0;
        addr     = '0;
        wrcs     = 1'b0;
        mask     = '0;
        wdata    = '0;
        rstn     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("reset_rsp", 32'(rsp_v[s]), 32'd0);
            chk("reset_rdata", rdata_v[s], 32'd0);
            chk("reset_gnt", 32'(gnt_v[s]), 32'd1);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Fill the first 16 words of every device so all later reads are known.
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            for (int i = 0; i < 16; i++) issue(RIB_WR, 32'(i * 4), 4'hF, $urandom());
            drain();
        end

        // Zero-wait device: write/read, byte mask, empty mask, aliasing.
        sel = 2'd0;
        issue(RIB_WR, 32'h100, 4'hF, 32'hDEADBEEF);
        issue(RIB_RD, 32'h100, 4'hF, 32'h0);
        issue(RIB_WR, 32'h104, 4'hF, 32'h11223344);
        issue(RIB_WR, 32'h104, 4'b0101, 32'hAABBCCDD);
        issue(RIB_RD, 32'h104, 4'h0, 32'h0);
        issue(RIB_WR, 32'h108, 4'h0, 32'hFFFFFFFF);
        issue(RIB_RD, 32'h108, 4'h0, 32'h0);
        issue(RIB_WR, 32'h0, 4'hF, 32'h5A5A5A5A);
        issue(RIB_RD, 32'h40, 4'h0, 32'h0);
        drain();

        // Back-to-back reads with req and rdy held high.
        for (int i = 0; i < 8; i++) issue(RIB_WR, 32'(i * 4), 4'hF, 32'hC0DE0000 + 32'(i));
        drain();
        c0 = cyc;
        for (int i = 0; i < 8; i++) issue(RIB_RD, 32'(i * 4), 4'hF, 32'h0);
        chk("b2b_accept_cycles", 32'(cyc - c0), 32'd8);
        drain();

        // Three-wait device: response held while rdy is low.
        sel     = 2'd1;
        issue(RIB_WR, 32'h0C, 4'hF, 32'h600DF00D);
        drain();
        rdy_man = 1'b0;
        issue(RIB_RD, 32'h0C, 4'hF, 32'h0);
        n = 0;
        while (!rsp_s && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_rsp_seen", 32'(rsp_s), 32'd1);
        held = rdata_s;
        chk("hold_first_rdata", held, 32'h600DF00D);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp", 32'(rsp_s), 32'd1);
            chk("hold_rdata", rdata_s, held);
            chk("hold_gnt", 32'(gnt_s), 32'd0);
        end
        @(posedge clk);
        #1;
        rdy_man = 1'b1;
        drain();

        // Two-wait device: reset one cycle after accepting a read.
        sel = 2'd2;
        issue(RIB_WR, 32'h14, 4'hF, 32'hC0FFEE11);
        drain();
        issue(RIB_RD, 32'h14, 4'hF, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        sbq.delete();
        seen = 1'b0;
        chk("midrst_rsp", 32'(rsp_s), 32'd0);
        chk("midrst_rdata", rdata_s, 32'd0);
        chk("midrst_gnt", 32'(gnt_s), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", 32'(gnt_s), 32'd1);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        issue(RIB_RD, 32'h14, 4'hF, 32'h0);
        drain();

        // Randomized traffic on every device with random rdy back-pressure.
        for (int s = 0; s < 3; s++) begin
            sel      = 2'(s);
            rdy_rand = 1'b1;
            for (int i = 0; i < 150; i++) begin
                issue(1'($urandom_range(0, 1)), rnd_addr(int'($urandom_range(0, 15))),
                      4'($urandom_range(0, 15)), $urandom());
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            drain();
            rdy_rand = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
